// File: rtl/via_arb_pkg.sv
// rtl/via_arb_pkg.sv - shared FSM encoding, VIA register map and helpers for via_bus_arbiter
package via_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ARMED = 2'd1;
    localparam arb_state_t ST_DONE  = 2'd2;

    localparam int IDX_W   = 2;
    localparam int MAX_REQ = 4;

    localparam logic [3:0] RS_ORB    = 4'h0;
    localparam logic [3:0] RS_ORA    = 4'h1;
    localparam logic [3:0] RS_DDRB   = 4'h2;
    localparam logic [3:0] RS_DDRA   = 4'h3;
    localparam logic [3:0] RS_T1CL   = 4'h4;
    localparam logic [3:0] RS_T1CH   = 4'h5;
    localparam logic [3:0] RS_T2CL   = 4'h8;
    localparam logic [3:0] RS_T2CH   = 4'h9;
    localparam logic [3:0] RS_SR     = 4'hA;
    localparam logic [3:0] RS_ACR    = 4'hB;
    localparam logic [3:0] RS_PCR    = 4'hC;
    localparam logic [3:0] RS_IFR    = 4'hD;
    localparam logic [3:0] RS_IER    = 4'hE;
    localparam logic [3:0] RS_ORA_NH = 4'hF;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // Round-robin start index for the grant after the one given to idx.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int num_req);
        return (int'(idx) == num_req - 1) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/via_arb_pick.sv
// rtl/via_arb_pick.sv - combinational winner select (round-robin with VIA_ARB_RR_EN, else fixed priority)
module via_arb_pick
    import via_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
)
(
    input  logic [NUM_REQ-1:0] req,
`ifdef VIA_ARB_RR_EN
    input  logic [IDX_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic found;

    assign any = |req;

`ifdef VIA_ARB_RR_EN
    // Walk requesters starting at ptr, wrapping; first one requesting wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IDX_W'(i);
                end
            end
        end
    end
`else
    // Lowest requesting index wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/via_bus_arbiter.sv
// rtl/via_bus_arbiter.sv - shares one MOS6522 VIA port among NUM_REQ requesters; VIA_ARB_RR_EN selects round-robin
module via_bus_arbiter
    import via_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
)
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   CLK_en,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [NUM_REQ-1:0]     REQ_RnW,
    input  logic [4*NUM_REQ-1:0]   REQ_RS,
    input  logic [8*NUM_REQ-1:0]   REQ_WDATA,
    output logic [NUM_REQ-1:0]     ACK,
    output logic                   ERR,
    output logic [7:0]             RDATA,
    output logic                   BUSY,
    output logic                   VIA_CS1,
    output logic                   VIA_nCS2,
    output logic                   VIA_RnW,
    output logic [3:0]             VIA_RS,
    output logic [7:0]             VIA_WDATA,
    output logic                   VIA_DOE,
    input  logic [7:0]             VIA_RDATA
);

    arb_state_t           state;
    logic [7:0]           cnt;
    logic [NUM_REQ-1:0]   win_oh;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [3:0]           rs_lane  [MAX_REQ];
    logic [7:0]           wd_lane  [MAX_REQ];
    logic                 rnw_lane [MAX_REQ];

    // Unpack requester buses into fixed-size lanes so the 2-bit winner index selects directly.
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_lane
        if (g < NUM_REQ) begin : g_used
            assign rs_lane[g]  = REQ_RS[4*g +: 4];
            assign wd_lane[g]  = REQ_WDATA[8*g +: 8];
            assign rnw_lane[g] = REQ_RnW[g];
        end else begin : g_pad
            assign rs_lane[g]  = 4'h0;
            assign wd_lane[g]  = 8'h00;
            assign rnw_lane[g] = 1'b1;
        end
    end

`ifdef VIA_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // Search start moves past each winner at grant time.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_ptr <= '0;
        end else if (state == ST_IDLE && pick_any) begin
            rr_ptr <= rr_next(pick_idx, NUM_REQ);
        end
    end

    via_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (REQ),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );
`else
    via_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (REQ),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );
`endif

    assign BUSY = (state != ST_IDLE);

    // Access sequencer: grant, hold CS until the first CLK_en after the grant edge (or timeout), then ack.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            win_oh    <= '0;
            ACK       <= '0;
            ERR       <= 1'b0;
            RDATA     <= 8'h00;
            VIA_CS1   <= 1'b0;
            VIA_nCS2  <= 1'b1;
            VIA_RnW   <= 1'b1;
            VIA_RS    <= 4'h0;
            VIA_WDATA <= 8'h00;
            VIA_DOE   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ACK <= '0;
                    ERR <= 1'b0;
                    if (pick_any) begin
                        win_oh    <= pick_grant;
                        VIA_RnW   <= rnw_lane[pick_idx];
                        VIA_RS    <= rs_lane[pick_idx];
                        VIA_WDATA <= wd_lane[pick_idx];
                        VIA_DOE   <= ~rnw_lane[pick_idx];
                        VIA_CS1   <= 1'b1;
                        VIA_nCS2  <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (CLK_en) begin
                        if (VIA_RnW) begin
                            RDATA <= VIA_RDATA;
                        end
                        VIA_CS1  <= 1'b0;
                        VIA_nCS2 <= 1'b1;
                        VIA_DOE  <= 1'b0;
                        ACK      <= win_oh;
                        state    <= ST_DONE;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        RDATA    <= TIMEOUT_RDATA;
                        ERR      <= 1'b1;
                        VIA_CS1  <= 1'b0;
                        VIA_nCS2 <= 1'b1;
                        VIA_DOE  <= 1'b0;
                        ACK      <= win_oh;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    ACK   <= '0;
                    ERR   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
